// File: rtl/satd_pkg.sv
// Shared types and constants for the SATD best-match search controller.
package satd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_DRAIN,
        S_REPORT
    } satd_ctrl_state_t;

    localparam int COST_W_DEFAULT = 16;
    localparam logic [COST_W_DEFAULT-1:0] COST_MAX = '1;

endpackage

// File: rtl/satd_min_tracker.sv
// Registered running minimum of SATD costs; strict less-than keeps the lowest index on ties.
module satd_min_tracker
    import satd_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int COST_W = COST_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [COST_W-1:0] cost,
    input  logic [IDX_W-1:0]  idx,
    output logic [COST_W-1:0] best_cost,
    output logic [IDX_W-1:0]  best_idx
);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            best_cost <= '1;
            best_idx  <= '0;
        end else if (load && (cost < best_cost)) begin
            best_cost <= cost;
            best_idx  <= idx;
        end
    end

endmodule

// File: rtl/satd_search_ctrl.sv
// Sequences one SATD unit over a candidate list and reports the lowest-cost candidate.
module satd_search_ctrl
    import satd_pkg::*;
#(
    parameter int MAX_CAND = 64,
    parameter int IDX_W    = $clog2(MAX_CAND),
    parameter int COST_W   = COST_W_DEFAULT,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W:0]    num_cand,
    output logic              busy,
    output logic              cand_req,
    output logic [IDX_W-1:0]  cand_idx,
    input  logic              cand_valid,
    output logic              satd_init,
    input  logic              satd_done,
    input  logic [COST_W-1:0] satd_result,
    output logic              satd_ack,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [COST_W-1:0] best_cost,
    output logic [IDX_W-1:0]  best_idx,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]   N_ONE   = 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    satd_ctrl_state_t state, state_next;

    logic [IDX_W:0]   ncand;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    logic             last_cand;
    logic             start_ok;
    logic             hit;

    assign timed_out = (wait_cnt == CNT_MAX);
    assign last_cand = ({1'b0, idx} == (ncand - N_ONE));
    assign start_ok  = (state == S_IDLE) && start;
    assign hit       = (state == S_WAIT) && satd_done;
    assign cand_idx  = idx;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        cand_req   = 1'b0;
        satd_init  = 1'b0;
        satd_ack   = 1'b0;
        res_valid  = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = (num_cand == '0) ? S_REPORT : S_FETCH;
            S_FETCH: begin
                cand_req = 1'b1;
                if (cand_valid) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                satd_init  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the timeout edge still counts.
                if (satd_done)      state_next = S_ACK;
                else if (timed_out) state_next = S_REPORT;
            end
            S_ACK: begin
                satd_ack   = 1'b1;
                state_next = S_DRAIN;
            end
            S_DRAIN:  if (!satd_done) state_next = last_cand ? S_REPORT : S_FETCH;
            S_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ncand       <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ncand       <= num_cand;
                    idx         <= '0;
                    timeout_err <= 1'b0;
                end
                S_ISSUE: wait_cnt <= '0;
                S_WAIT: if (!satd_done) begin
                    if (timed_out) timeout_err <= 1'b1;
                    else           wait_cnt    <= wait_cnt + CNT_ONE;
                end
                S_DRAIN: if (!satd_done && !last_cand) idx <= idx + IDX_ONE;
                default: ;
            endcase
        end
    end

    satd_min_tracker #(
        .IDX_W (IDX_W),
        .COST_W(COST_W)
    ) u_min (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_ok),
        .load     (hit),
        .cost     (satd_result),
        .idx      (idx),
        .best_cost(best_cost),
        .best_idx (best_idx)
    );

endmodule

// File: tb/tb_satd_search_ctrl.sv
// Bench for satd_search_ctrl: fetch/SATD responder, scoreboard minimum model, per-cycle protocol checks.
module tb_satd_search_ctrl;
    import satd_pkg::*;

    localparam int MAX_CAND = 64;
    localparam int IDX_W    = 6;
    localparam int COST_W   = 16;
    localparam int TIMEOUT  = 255;

    typedef int cost_arr_t [MAX_CAND];

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [IDX_W:0]    num_cand = '0;
    logic              cand_valid = 1'b0;
    logic              satd_done = 1'b0;
    logic [COST_W-1:0] satd_result = '0;
    logic              res_ready = 1'b1;
    logic              busy, cand_req, satd_init, satd_ack, res_valid, timeout_err;
    logic [IDX_W-1:0]  cand_idx, best_idx;
    logic [COST_W-1:0] best_cost;

    satd_search_ctrl #(
        .MAX_CAND(MAX_CAND), .IDX_W(IDX_W), .COST_W(COST_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_cand(num_cand), .busy(busy),
        .cand_req(cand_req), .cand_idx(cand_idx), .cand_valid(cand_valid),
        .satd_init(satd_init), .satd_done(satd_done), .satd_result(satd_result),
        .satd_ack(satd_ack), .res_valid(res_valid), .res_ready(res_ready),
        .best_cost(best_cost), .best_idx(best_idx), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    cost_arr_t costs;
    int sat_lat = 2;
    int lat_rand = 0;
    int fdmax = 0;
    int noise = 0;
    int hang_cand = -1;
    int cur_n = 0;

    int inits = 0, acks = 0, reqs = 0, cyc = 0, init_cyc = 0, rv_cyc = 0;
    cost_arr_t acc;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Lowest cost among candidates 0..n-1, starting from all-ones; earliest index wins a tie.
    function automatic void model_best(input cost_arr_t c, input int n, output int bc, output int bi);
        bc = 65535;
        bi = 0;
        for (int i = 0; i < n; i++) begin
            if (c[i] < bc) begin
                bc = c[i];
                bi = i;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch logic and SATD unit model, driven just after each rising edge.
    initial begin
        int fw, scnt, lat;
        logic sbusy, shang;
        logic [COST_W-1:0] scost;
        fw = -1; scnt = 0; sbusy = 0; shang = 0; scost = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                cand_valid = 0; satd_done = 0; fw = -1; sbusy = 0;
            end else begin
                cand_valid = 0;
                if (cand_req) begin
                    if (fw < 0) fw = $urandom_range(0, fdmax);
                    if (fw == 0) begin
                        cand_valid = 1;
                        fw = -1;
                    end else fw--;
                end else begin
                    fw = -1;
                    if (noise != 0) cand_valid = ($urandom_range(0, 3) == 0);
                end
                if (satd_ack && satd_done) begin
                    satd_done = 0;
                    sbusy = 0;
                end else if (satd_init) begin
                    lat = (lat_rand != 0) ? $urandom_range(1, 4) : sat_lat;
                    sbusy = 1;
                    scnt = lat;
                    scost = COST_W'(costs[cand_idx]);
                    shang = (int'(cand_idx) == hang_cand);
                end else if (sbusy && !satd_done && !shang) begin
                    if (scnt <= 1) satd_done = 1;
                    else scnt--;
                end
                if (res_valid) begin
                    sbusy = 0;
                    satd_done = 0;
                end
                satd_result = satd_done ? scost : COST_W'($urandom);
            end
        end
    end

    // Per-cycle protocol and result checks against the scoreboard.
    logic pbusy = 0, pinit = 0, pack = 0, pdone = 0, prv = 0, prdy = 0, pcv = 0, preq = 0;
    logic pto = 0, pcreq = 0;
    logic [COST_W-1:0] pcost = '0;
    logic [IDX_W-1:0]  pidx = '0;

    initial begin
        int bc, bi, exp_to, exp_acks;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                pbusy = 0; pinit = 0; pack = 0; pdone = 0; prv = 0; prdy = 0; pcv = 0; preq = 0;
            end else begin
                if (busy && !pbusy) begin
                    inits = 0; acks = 0; reqs = 0;
                end
                if (cand_req) begin
                    reqs++;
                    chk("req_idx", cand_idx, inits);
                end
                if (satd_init) begin
                    chk("init_single", pinit, 0);
                    chk("init_after_valid", pcv && preq, 1);
                    chk("init_idx", cand_idx, inits);
                    inits++;
                    init_cyc = cyc;
                end
                if (satd_ack) begin
                    chk("ack_single", pack, 0);
                    chk("ack_after_done", pdone, 1);
                    chk("ack_idx", cand_idx, acks);
                    if (acks < MAX_CAND) acc[acks] = costs[cand_idx];
                    acks++;
                end
                if (res_valid && !prv) begin
                    rv_cyc = cyc;
                    exp_to = (hang_cand >= 0 && hang_cand < cur_n) ? 1 : 0;
                    exp_acks = (exp_to != 0) ? hang_cand : cur_n;
                    model_best(acc, acks, bc, bi);
                    chk("res_best_cost", best_cost, bc);
                    chk("res_best_idx", best_idx, bi);
                    chk("res_timeout", timeout_err, exp_to);
                    chk("res_acks", acks, exp_acks);
                    chk("res_busy", busy, 1);
                end
                if (prv && !prdy) begin
                    chk("hold_valid", res_valid, 1);
                    chk("hold_cost", best_cost, pcost);
                    chk("hold_idx", best_idx, pidx);
                    chk("hold_timeout", timeout_err, pto);
                    chk("hold_quiet", {cand_req, satd_init, satd_ack}, 0);
                end
                if (pbusy && prv && prdy) begin
                    chk("release_busy", busy, 0);
                    chk("release_valid", res_valid, 0);
                end
                pbusy = busy; pinit = satd_init; pack = satd_ack; pdone = satd_done;
                prv = res_valid; prdy = res_ready; pcv = cand_valid; preq = cand_req;
                pcost = best_cost; pidx = best_idx; pto = timeout_err; pcreq = cand_req;
            end
        end
    end

    task automatic run_search(input int n, output int waited);
        cur_n = n;
        num_cand = (IDX_W+1)'(n);
        start = 1;
        tick();
        start = 0;
        waited = 0;
        while (!res_valid && waited < 5000) begin
            tick();
            waited++;
        end
        if (!res_valid) chk("search_finished", 0, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cand_req"}, cand_req, 0);
        chk({tag, "_cand_idx"}, cand_idx, 0);
        chk({tag, "_satd_init"}, satd_init, 0);
        chk({tag, "_satd_ack"}, satd_ack, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_best_cost"}, best_cost, COST_MAX);
        chk({tag, "_best_idx"}, best_idx, 0);
    endtask

    initial begin
        cost_arr_t t;
        int bc, bi, w;

        t = '{default: 65535};
        model_best(t, 3, bc, bi);
        chk("pin_allmax_cost", bc, 65535);
        chk("pin_allmax_idx", bi, 0);
        t[0] = 300; t[1] = 120; t[2] = 120; t[3] = 500;
        model_best(t, 4, bc, bi);
        chk("pin_tie_cost", bc, 120);
        chk("pin_tie_idx", bi, 1);
        costs = '{default: 0};

        reset = 0;
        repeat (2) tick();
        chk_reset_outputs("reset");
        reset = 1;
        tick();

        // Basic 4-candidate search with a tie
        costs[0] = 300; costs[1] = 120; costs[2] = 120; costs[3] = 500;
        sat_lat = 2;
        run_search(4, w);
        chk("basic_cost", best_cost, 120);
        chk("basic_idx", best_idx, 1);
        chk("basic_timeout", timeout_err, 0);
        tick();
        chk("basic_inits", inits, 4);
        chk("basic_acks", acks, 4);
        chk("basic_idle", busy, 0);

        // Empty candidate list
        run_search(0, w);
        chk("empty_latency", w, 0);
        chk("empty_cost", best_cost, 16'hFFFF);
        chk("empty_idx", best_idx, 0);
        tick();
        chk("empty_reqs", reqs, 0);

        // SATD hangs on candidate 2 of 5
        costs[0] = 900; costs[1] = 400; costs[2] = 50; costs[3] = 10; costs[4] = 5;
        hang_cand = 2;
        run_search(5, w);
        chk("to_cost", best_cost, 400);
        chk("to_idx", best_idx, 1);
        chk("to_flag", timeout_err, 1);
        tick();
        chk("to_latency", rv_cyc - init_cyc, TIMEOUT + 2);
        chk("to_inits", inits, 3);
        hang_cand = -1;

        // Consumer stalls; start pulse during REPORT must be ignored
        costs[0] = 10; costs[1] = 20; costs[2] = 5;
        res_ready = 0;
        run_search(3, w);
        for (int k = 0; k < 10; k++) begin
            start = (k == 3);
            tick();
            chk("stall_valid", res_valid, 1);
            chk("stall_busy", busy, 1);
        end
        start = 0;
        res_ready = 1;
        tick();
        chk("stall_release_busy", busy, 0);
        chk("stall_release_valid", res_valid, 0);
        run_search(2, w);
        chk("restart_cost", best_cost, 10);
        chk("restart_idx", best_idx, 0);
        tick();

        // Reset while waiting on candidate 3
        costs[0] = 50; costs[1] = 40; costs[2] = 30; costs[3] = 20; costs[4] = 10;
        sat_lat = 8;
        cur_n = 5;
        num_cand = 5;
        start = 1;
        tick();
        start = 0;
        w = 0;
        while (!(satd_init && cand_idx == 3) && w < 2000) begin
            tick();
            w++;
        end
        chk("abort_reached_c3", satd_init && cand_idx == 3, 1);
        tick();
        reset = 0;
        tick();
        chk_reset_outputs("abort");
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_ack", satd_ack, 0);
            chk("abort_idle", busy, 0);
        end

        // Full-size randomized searches
        fdmax = 3;
        lat_rand = 1;
        noise = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < MAX_CAND; i++) begin
                if (r == 0)      costs[i] = $urandom_range(0, 15);
                else if (r == 1) costs[i] = ($urandom_range(0, 7) == 0) ? 65535 : $urandom_range(0, 65535);
                else             costs[i] = 65535;
            end
            run_search(MAX_CAND, w);
            if (r == 2) begin
                chk("rand_allmax_cost", best_cost, 16'hFFFF);
                chk("rand_allmax_idx", best_idx, 0);
            end
            tick();
            chk("rand_inits", inits, MAX_CAND);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
